sram_arb_2p: RTL

Two-port arbiter and sequencer for the single-port 1024x32 on-chip SRAM macro wrapper. It shares one SRAM between two requesters, port 0 (typically data) and port 1 (typically instruction fetch), using a req/gnt handshake with a one-cycle-later read response. It also runs an optional post-reset clear sequence that zero-fills the whole array before any requester is granted. It sits between the bus adapters and the SRAM wrapper inside the on-chip RAM subsystem.

---
 rtl/sram_arb_2p.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_arb_2p.sv
// sram_arb_2p: shares one single-port SRAM between two req/gnt requesters.
// After reset it can zero-fill the whole array before any requester is
// served. Grants are combinational. The response comes one cycle after
// the grant, for reads and writes alike.
module sram_arb_2p #(
  parameter int unsigned AW             = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          p0_req_i,
  input  logic [AW-1:0] p0_addr_i,
  input  logic          p0_wren_i,
  input  logic [31:0]   p0_data_i,
  input  logic [3:0]    p0_mask_i,
  output logic          p0_gnt_o,
  output logic          p0_rvalid_o,
  output logic [31:0]   p0_rdata_o,

  input  logic          p1_req_i,
  input  logic [AW-1:0] p1_addr_i,
  input  logic          p1_wren_i,
  input  logic [31:0]   p1_data_i,
  input  logic [3:0]    p1_mask_i,
  output logic          p1_gnt_o,
  output logic          p1_rvalid_o,
  output logic [31:0]   p1_rdata_o,

  output logic          sram_cs_o,
  output logic          sram_wren_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_data_o,
  output logic [3:0]    sram_mask_o,
  input  logic [31:0]   sram_data_i,

  output logic          init_done_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] CLR_LAST    = {AW{1'b1}};
  localparam state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] clr_cnt_d;
  logic          last_q;
  logic          last_d;
  logic          p0_rvalid_q;
  logic          p1_rvalid_q;
  logic          p0_gnt;
  logic          p1_gnt;

  // Pick at most one requester per cycle. Nothing is granted during reset or the clear sweep.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst_i && (state_q == ST_RUN)) begin
      if (p0_req_i && p1_req_i) begin
        if (FIXED_PRIO || last_q) begin
          p0_gnt = 1'b1;
        end else begin
          p1_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req_i;
        p1_gnt = p1_req_i;
      end
    end
  end

  // Next-state logic and SRAM bus mux: the clear sweep in CLEAR, the granted port in RUN.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    last_d      = last_q;
    sram_cs_o   = 1'b0;
    sram_wren_o = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    sram_mask_o = '0;

    case (state_q)
      ST_CLEAR: begin
        if (!rst_i) begin
          sram_cs_o   = 1'b1;
          sram_wren_o = 1'b1;
          sram_mask_o = 4'hF;
          sram_addr_o = clr_cnt_q;
          clr_cnt_d   = clr_cnt_q + AW'(1);
          if (clr_cnt_q == CLR_LAST) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (p0_gnt) begin
          sram_cs_o   = 1'b1;
          sram_wren_o = p0_wren_i;
          sram_addr_o = p0_addr_i;
          sram_data_o = p0_data_i;
          sram_mask_o = p0_mask_i;
          last_d      = 1'b0;
        end else if (p1_gnt) begin
          sram_cs_o   = 1'b1;
          sram_wren_o = p1_wren_i;
          sram_addr_o = p1_addr_i;
          sram_data_o = p1_data_i;
          sram_mask_o = p1_mask_i;
          last_d      = 1'b1;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State, clear counter, round-robin history and the response flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      last_q      <= 1'b1;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      last_q      <= last_d;
      p0_rvalid_q <= p0_gnt;
      p1_rvalid_q <= p1_gnt;
    end
  end

  assign p0_gnt_o    = p0_gnt;
  assign p1_gnt_o    = p1_gnt;
  assign p0_rvalid_o = p0_rvalid_q & ~rst_i;
  assign p1_rvalid_o = p1_rvalid_q & ~rst_i;
  assign p0_rdata_o  = p0_rvalid_o ? sram_data_i : 32'h0;
  assign p1_rdata_o  = p1_rvalid_o ? sram_data_i : 32'h0;
  assign init_done_o = (state_q == ST_RUN) & ~rst_i;

endmodule
